// File: rtl/uart_tx_8.sv
`default_nettype none
// ============================================================================
// uart_tx_8 : 8N1 UART transmitter (1 start, 8 data LSB-first, 1 stop)
// Revision  : 1.0
// ============================================================================
module uart_tx_8 #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       data, data_n;
  logic             tx_n, busy_n, done_n;
  logic             bit_end;
  logic [2:0]       idx_inc;

  assign bit_end = (cnt == CNT_LAST);
  assign idx_inc = idx + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
      data  <= 8'd0;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      data  <= data_n;
      tx    <= tx_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // tx is registered, so the value for the next bit is loaded at each bit boundary
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    data_n  = data;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        cnt_n  = '0;
        idx_n  = 3'd0;
        if (tx_start) begin
          data_n  = tx_data;
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = 3'd0;
          state_n = DATA;
          tx_n    = data[0];
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            idx_n   = 3'd0;
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            idx_n = idx_inc;
            tx_n  = data[idx_inc];
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          cnt_n   = '0;
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_8.sv
`default_nettype none
// Testbench for uart_tx_8: scoreboard of expected bytes/start cycles, line monitor decodes frames.
module tb_uart_tx_8;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, busy, done;

  uart_tx_8 #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  logic [7:0] exp_q[$];
  int         cyc_q[$];

  bit         mon_en = 1'b0;
  bit         in_frame = 1'b0;
  int         n = 0;
  logic [7:0] cur = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int slot);
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return d[slot-1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    exp_q.push_back(d);
    cyc_q.push_back(cyc + 1);
    tick();
    tx_start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !in_frame) break;
      tick();
    end
    check("drain", {31'd0, (exp_q.size() != 0) || in_frame}, 32'd0);
    repeat (3) tick();
  endtask

  // Line monitor: pops the scoreboard at each start bit and checks every cycle of the frame
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && tx === 1'b0) begin
          in_frame = 1'b1;
          n = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", exp_q.size(), 32'd1);
            cur = 8'h00;
          end else begin
            cur = exp_q.pop_front();
            check("start_cycle", cyc, cyc_q.pop_front());
          end
        end
        if (in_frame) begin
          if (n < FRAME) begin
            check("tx_bit", tx, frame_bit(cur, n / CPB));
            check("busy_frame", busy, 1);
            check("done_frame", done, 0);
            n++;
          end else begin
            check("done_end", done, 1);
            check("busy_end", busy, 0);
            check("tx_end", tx, 1);
            in_frame = 1'b0;
          end
        end else begin
          check("busy_idle", busy, 0);
          check("done_idle", done, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // 1. Reset hold
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    rst    = 1'b1;
    mon_en = 1'b1;
    repeat (5) tick();

    // 2. Single byte
    send(8'hA5);
    wait_drain();

    // 3. Edge-case data
    send(8'h00);
    wait_drain();
    send(8'hFF);
    wait_drain();

    // 4. Requests during a frame are ignored
    send(8'h3C);
    repeat (9) tick();
    tx_data  = 8'hFF;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (9) tick();
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    wait_drain();

    // 5. Back-to-back: request held high until accepted in the done cycle
    send(8'h5A);
    repeat (29) tick();
    tx_data  = 8'h81;
    tx_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) break;
      tick();
    end
    check("b2b_done_seen", done, 1);
    exp_q.push_back(8'h81);
    cyc_q.push_back(cyc + 1);
    tick();
    tx_start = 1'b0;
    wait_drain();

    // 6. Reset mid-frame
    send(8'h96);
    repeat (14) tick();
    rst = 1'b0;
    tick();
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    tick();
    rst = 1'b1;
    repeat (50) tick();
    check("abort_queue", exp_q.size(), 0);
    send(8'hC3);
    wait_drain();

    check("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
